spi_slave_gen: RTL
==================

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning bits per SPI word (legal 4..32).
REQ-002 The module SHALL have parameter CPOL, default 0, meaning spiClk idle level.
REQ-003 The module SHALL have parameter CPHA, default 0, meaning 0 = sample on leading edge and 1 = sample on trailing edge.
REQ-004 The module SHALL have parameter MSB_FIRST, default 1, meaning bit order on both mosi and miso.
REQ-005 The module SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser depth for spiClk, cs and mosi (legal 2..4).
REQ-006 The module SHALL have port sysClk  in  1  system clock; sole clock; every flop is on its rising edge.
REQ-007 The module SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-008 The module SHALL have port spiClk  in  1  SPI clock from master, asynchronous.
REQ-009 The module SHALL have port cs  in  1  slave select from master, active-low, asynchronous.
REQ-010 The module SHALL have port mosi  in  1  master-out data, asynchronous.
REQ-011 The module SHALL have port miso  out  1  slave-out data, registered.
REQ-012 The module SHALL have port tx_data  in  DATA_WIDTH  next word to transmit.
REQ-013 The module SHALL have port tx_valid  in  1  tx_data is valid.
REQ-014 The module SHALL have port tx_ready  out  1  tx holding register is empty.
REQ-015 The module SHALL have port rx_data  out  DATA_WIDTH  last received word.
REQ-016 The module SHALL have port rx_valid  out  1  rx_data holds an unconsumed word.
REQ-017 The module SHALL have port rx_ready  in  1  consumer accepts rx_data.
REQ-018 The module SHALL have port busy  out  1  cs is synchronised low.
REQ-019 The module SHALL have port overrun  out  1  one-cycle pulse when a received word overwrites an unconsumed one.
REQ-020 The module SHALL have port underrun  out  1  one-cycle pulse when a word load finds the holding register empty.

Function
REQ-021 spiClk, cs and mosi SHALL each pass through SYNC_STAGES flops, and edges SHALL be detected by comparing the last stage against one further registered copy.
REQ-022 No logic SHALL be clocked by spiClk or cs; all processing is in the sysClk domain.
REQ-023 The leading edge SHALL be rising when CPOL=0 and falling when CPOL=1; the trailing edge is the opposite edge.
REQ-024 The sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; the shift edge is the other edge.
REQ-025 The FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on synced cs falling edge; ACTIVE->IDLE on synced cs rising edge; cs rising SHALL win over any same-cycle spiClk edge.
REQ-026 A word load SHALL occur on IDLE->ACTIVE and on every shift edge that follows the final sample of a word.
REQ-027 A word load SHALL copy the holding register into the tx shift register and mark the holding register empty; if it is already empty, the shift register SHALL load all zeros and underrun SHALL pulse.
REQ-028 With CPHA=0, miso SHALL present the first bit one sysClk after the load; with CPHA=1, miso SHALL present the first bit one sysClk after the first leading edge.
REQ-029 Each shift edge SHALL present the next bit on miso; bit order SHALL be MSB-first when MSB_FIRST=1, else LSB-first.
REQ-030 Each sample edge SHALL shift synced mosi into the rx shift register and increment a bit counter of width clog2(DATA_WIDTH).
REQ-031 At the DATA_WIDTH-th sample, the bit counter SHALL wrap to 0, rx_data SHALL load the assembled word one sysClk later, and rx_valid SHALL be set.
REQ-032 If rx_valid is still set and rx_ready is low when a new word completes, rx_data SHALL be overwritten and overrun SHALL pulse.
REQ-033 rx_valid SHALL clear on a cycle with rx_valid&&rx_ready, unless a new word completes in that same cycle, in which case it SHALL stay set with no overrun.
REQ-034 tx_ready SHALL be high while the holding register is empty, and tx_valid&&tx_ready SHALL capture tx_data.
REQ-035 A capture and a load in the same cycle SHALL pass the captured word straight to the shift register, with no underrun.
REQ-036 A cs rise mid-word SHALL discard the partial rx bits, reset the bit counter, and leave rx_data, rx_valid and the holding register untouched.
REQ-037 miso SHALL drive 0 whenever the FSM is in IDLE.
REQ-038 busy SHALL be high exactly while the FSM is in ACTIVE.

Reset
REQ-039 When reset_n is low at a sysClk edge, the FSM SHALL enter IDLE; synchroniser flops SHALL take the idle values CPOL/1/0.
REQ-040 Reset SHALL drive miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, overrun=0, underrun=0, and clear the holding register, shift registers and bit counter.
REQ-041 A reset asserted mid-transfer SHALL abort the transfer, and the block SHALL wait for a fresh cs falling edge before any new transfer.

Verification
REQ-042 Mode 0, W=8: preload tx=0x79; master sends 0xA1 -> master receives 0x79; rx_data=0xA1 and rx_valid=1.
REQ-043 Modes 1-3, W=8: tx=0x99; master sends 0x2A -> master receives 0x99; rx_data=0x2A in each mode.
REQ-044 Mode 0, W=16, MSB_FIRST=0: 3 back-to-back words under one cs, tx refilled on tx_ready -> all 3 words exchanged intact, no underrun.
REQ-045 Holding register empty at cs fall -> master receives 0x00 and underrun pulses once.
REQ-046 rx_ready held low for 2 words -> overrun pulses once and rx_data equals the second word.
REQ-047 cs raised after 5 bits, then a full transfer of 0xE4 -> rx_data=0xE4 and the partial bits are discarded; reset_n pulsed mid-word -> all outputs return to their REQ-040 values.

Source files
------------

// File: rtl/spi_slave_gen.sv
// SPI slave with all logic in the sysClk domain: synchronised spiClk/cs/mosi,
// edge-detected shifting, a one-word tx holding register and an rx output register.
`timescale 1ns/1ps
module spi_slave_gen #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  sysClk,
    input  logic                  reset_n,
    input  logic                  spiClk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  underrun
);
    localparam int unsigned CNT_W    = $clog2(DATA_WIDTH);
    localparam int unsigned FLUSH    = SYNC_STAGES + 1;
    localparam logic        IDLE_CLK = 1'(CPOL);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [2:0]             flush_q;
    logic                   armed_q;
    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  hold_q, tx_shift_q, rx_shift_q, rx_data_q;
    logic                   tx_empty_q, rx_valid_q, miso_q, busy_q;
    logic                   overrun_q, underrun_q, done_q, word_end_q;
    logic [CNT_W-1:0]       bit_cnt_q;

    logic                   sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic                   cs_fall, cs_rise, load, capture;
    logic [DATA_WIDTH-1:0]  load_word, shift_src, rx_shift_d;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    // Input synchronisers; cs is only trusted once a settled high has been seen after reset.
    always_ff @(posedge sysClk) begin
        if (!reset_n) begin
            sclk_sync_q <= {SYNC_STAGES{IDLE_CLK}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= IDLE_CLK;
            cs_prev_q   <= 1'b1;
            flush_q     <= 3'd0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spiClk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            if (flush_q != 3'(FLUSH)) flush_q <= flush_q + 3'd1;
            armed_q     <= armed_q | ((flush_q == 3'(FLUSH)) & cs_s);
        end
    end

    always_comb begin
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
        trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
        sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
        shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
        cs_fall     = ~cs_s & cs_prev_q & armed_q;
        cs_rise     = cs_s & ~cs_prev_q;
        capture     = tx_valid & tx_empty_q;
        load        = ((state_q == IDLE) & cs_fall)
                    | ((state_q == ACTIVE) & ~cs_rise & shift_edge & word_end_q);
        // A same-cycle capture goes straight through to the shift register.
        load_word   = !tx_empty_q ? hold_q : (capture ? tx_data : '0);
        shift_src   = load ? load_word : tx_shift_q;
        rx_shift_d  = (MSB_FIRST != 0) ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s}
                                       : {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge sysClk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            tx_empty_q <= 1'b1;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
            word_end_q <= 1'b0;
            bit_cnt_q  <= '0;
        end else begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;

            if (load) tx_empty_q <= 1'b1;
            else if (capture) begin
                hold_q     <= tx_data;
                tx_empty_q <= 1'b0;
            end
            if (load && tx_empty_q && !capture) underrun_q <= 1'b1;

            // Completed word lands one cycle after its final sample.
            if (done_q) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
                overrun_q  <= rx_valid_q & ~rx_ready;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        state_q    <= ACTIVE;
                        busy_q     <= 1'b1;
                        bit_cnt_q  <= '0;
                        word_end_q <= 1'b0;
                        rx_shift_q <= '0;
                        tx_shift_q <= (CPHA == 0) ? advance(load_word) : load_word;
                        miso_q     <= (CPHA == 0) ? first_bit(load_word) : 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        miso_q     <= 1'b0;
                        bit_cnt_q  <= '0;
                        word_end_q <= 1'b0;
                        rx_shift_q <= '0;
                        tx_shift_q <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift_q <= rx_shift_d;
                            if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                                bit_cnt_q  <= '0;
                                word_end_q <= 1'b1;
                                done_q     <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                        if (shift_edge) begin
                            miso_q     <= first_bit(shift_src);
                            tx_shift_q <= advance(shift_src);
                            if (load) word_end_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso     = miso_q;
    assign tx_ready = tx_empty_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;
endmodule
